// File: rtl/ysyx_22040931_idu_imm_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22040931_idu_imm_ctrl_pkg
// Brief   : Shared immediate-type encodings, RV opcode constants, XLEN default
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package ysyx_22040931_idu_imm_ctrl_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  // Decoded payload carried alongside each buffered beat.
  typedef struct packed {
    logic [31:0] instr;
    imm_type_e   imm_type;
    logic        illegal;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040931_imm_gen.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22040931_imm_gen
// Brief   : Core immediate generator, fed instr[31:7] and the immediate type
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040931_imm_gen
  import ysyx_22040931_idu_imm_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr_hi,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm
);

  // instr_hi[k] holds instr[k+7]
  logic [11:0] w_imm_i;
  logic [11:0] w_imm_s;
  logic [12:0] w_imm_b;
  logic [20:0] w_imm_j;
  logic [31:0] w_imm_u;

  assign w_imm_i = instr_hi[24:13];
  assign w_imm_s = {instr_hi[24:18], instr_hi[4:0]};
  assign w_imm_b = {instr_hi[24], instr_hi[0], instr_hi[23:18], instr_hi[4:1], 1'b0};
  assign w_imm_j = {instr_hi[24], instr_hi[12:5], instr_hi[13], instr_hi[23:14], 1'b0};
  assign w_imm_u = {instr_hi[24:5], 12'b0};

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{(XLEN-12){w_imm_i[11]}}, w_imm_i};
      IMM_S:   imm = {{(XLEN-12){w_imm_s[11]}}, w_imm_s};
      IMM_B:   imm = {{(XLEN-13){w_imm_b[12]}}, w_imm_b};
      IMM_J:   imm = {{(XLEN-21){w_imm_j[20]}}, w_imm_j};
      IMM_U:   imm = {{(XLEN-32){w_imm_u[31]}}, w_imm_u};
      default: imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040931_imm_sel.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22040931_imm_sel
// Brief   : Combinational opcode classifier -> immediate type and illegal flag
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040931_imm_sel
  import ysyx_22040931_idu_imm_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b1;
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32,
        OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
          imm_type = IMM_I;
          illegal  = 1'b0;
        end
        OPC_STORE: begin
          imm_type = IMM_S;
          illegal  = 1'b0;
        end
        OPC_BRANCH: begin
          imm_type = IMM_B;
          illegal  = 1'b0;
        end
        OPC_JAL: begin
          imm_type = IMM_J;
          illegal  = 1'b0;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_type = IMM_U;
          illegal  = 1'b0;
        end
        OPC_OP, OPC_OP32: begin
          illegal  = 1'b0;
        end
        default: begin
          imm_type = IMM_NONE;
          illegal  = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040931_idu_imm_ctrl.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22040931_idu_imm_ctrl
// Brief   : Decode-stage immediate controller with 2-entry skid buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040931_idu_imm_ctrl
  import ysyx_22040931_idu_imm_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [2:0]      out_imm_type,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [1:0]      occupancy
);

  localparam dec_t DEC_RESET = '{instr: 32'd0, imm_type: IMM_NONE, illegal: 1'b0};

  logic            r_head_valid;
  logic [XLEN-1:0] r_head_pc;
  dec_t            r_head_dec;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  dec_t            r_skid_dec;

  logic            w_accept;
  logic            w_fire;
  logic [2:0]      w_sel_type;
  logic            w_sel_illegal;
  dec_t            w_in_dec;

  ysyx_22040931_imm_sel u_imm_sel (
    .opcode   (in_instr[6:0]),
    .imm_type (w_sel_type),
    .illegal  (w_sel_illegal)
  );

  assign w_in_dec = '{instr: in_instr, imm_type: imm_type_e'(w_sel_type), illegal: w_sel_illegal};

  // in_ready is a pure function of state, so back-pressure never forms a comb path
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_fire   = r_head_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_valid <= 1'b0;
      r_head_pc    <= '0;
      r_head_dec   <= DEC_RESET;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_dec   <= DEC_RESET;
    end else if (flush) begin
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_head_valid || w_fire) begin
      if (r_skid_valid) begin
        // skid full implies in_ready low, so no new beat competes here
        r_head_valid <= 1'b1;
        r_head_pc    <= r_skid_pc;
        r_head_dec   <= r_skid_dec;
        r_skid_valid <= 1'b0;
      end else begin
        r_head_valid <= w_accept;
        if (w_accept) begin
          r_head_pc  <= in_pc;
          r_head_dec <= w_in_dec;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= in_pc;
      r_skid_dec   <= w_in_dec;
    end
  end

  ysyx_22040931_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_hi (r_head_dec.instr[31:7]),
    .imm_type (r_head_dec.imm_type),
    .imm      (out_imm)
  );

  assign out_valid    = r_head_valid;
  assign out_pc       = r_head_pc;
  assign out_instr    = r_head_dec.instr;
  assign out_imm_type = r_head_dec.imm_type;
  assign out_illegal  = r_head_dec.illegal;
  assign occupancy    = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040931_idu_imm_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_ysyx_22040931_idu_imm_ctrl
// Brief   : Scoreboard bench for the decode-stage immediate controller
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_22040931_idu_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_imm_type;
  logic [63:0] out_imm;
  logic        out_illegal;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  ysyx_22040931_idu_imm_ctrl #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_imm_type (out_imm_type),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal),
    .occupancy    (occupancy)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  logic acc_flag;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] ins,
                              input logic [2:0] typ, input logic [63:0] imm, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = ins; e.typ = typ; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  // Independent reference decoder for randomised traffic
  function automatic exp_t model(input logic [63:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc = pc; e.instr = ins; e.typ = 3'd0; e.imm = 64'd0; e.ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: begin
        e.typ = 3'd1; e.imm = {{52{ins[31]}}, ins[31:20]};
      end
      7'h23: begin e.typ = 3'd2; e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin e.typ = 3'd3; e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h6F: begin e.typ = 3'd4; e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h37, 7'h17: begin e.typ = 3'd5; e.imm = {{32{ins[31]}}, ins[31:12], 12'h000}; end
      7'h33, 7'h3B: e.typ = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: occupancy/handshake consistency, scoreboard pop on fire, push on accept
  task automatic tick();
    exp_t e;
    @(negedge clk);
    check("occupancy", occupancy, q.size());
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() != 0);
    acc_flag = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", out_pc, 64'hDEAD);
      end else begin
        e = q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_imm_type", out_imm_type, e.typ);
        check("out_imm", out_imm, e.imm);
        check("out_illegal", out_illegal, e.ill);
      end
    end
    if (flush) q.delete();
    else if (acc_flag) q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e, output int cycles);
    cur = e; in_valid = 1'b1; in_pc = e.pc; in_instr = e.instr;
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cycles++;
      if (acc_flag) break;
    end
    if (!acc_flag) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic reset_values(input string pfx);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_in_ready"}, in_ready, 1);
    check({pfx, "_occupancy"}, occupancy, 0);
    check({pfx, "_out_pc"}, out_pc, 0);
    check({pfx, "_out_instr"}, out_instr, 0);
    check({pfx, "_out_imm_type"}, out_imm_type, 0);
    check({pfx, "_out_imm"}, out_imm, 0);
    check({pfx, "_out_illegal"}, out_illegal, 0);
  endtask

  exp_t dir[12];
  logic [6:0] ops[16] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                          7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h7F, 7'h10, 7'h00};

  initial begin
    int cyc;
    exp_t a, b, c, nxt;
    logic pending;
    int sent;
    logic [31:0] r;

    dir[0]  = mk(64'h80000000, 32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    dir[1]  = mk(64'h80000004, 32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    dir[2]  = mk(64'h80000008, 32'h800002B7, 3'd5, 64'hFFFFFFFF80000000, 1'b0);
    dir[3]  = mk(64'h8000000C, 32'h0000007F, 3'd0, 64'h0, 1'b1);
    dir[4]  = mk(64'h80000010, 32'h002081B3, 3'd0, 64'h0, 1'b0);
    dir[5]  = mk(64'h80000014, 32'h00208463, 3'd3, 64'h8, 1'b0);
    dir[6]  = mk(64'h80000018, 32'h001000EF, 3'd4, 64'h800, 1'b0);
    dir[7]  = mk(64'h8000001C, 32'hFFFFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    dir[8]  = mk(64'h80000020, 32'h12345197, 3'd5, 64'h12345000, 1'b0);
    dir[9]  = mk(64'h80000024, 32'h00000010, 3'd0, 64'h0, 1'b1);
    dir[10] = mk(64'h80000028, 32'h00813083, 3'd1, 64'h8, 1'b0);
    dir[11] = mk(64'h8000002C, 32'h00000073, 3'd1, 64'h0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = 32'd0; in_pc = 64'd0;
    @(posedge clk); #1;
    reset_values("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed opcodes, back-to-back with out_ready high
    out_ready = 1'b1;
    send(dir[0], cyc);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_imm_type", out_imm_type, 3'd1);
    check("lat_out_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
    check("lat_out_pc", out_pc, 64'h80000000);
    for (int i = 1; i < 12; i++) begin
      send(dir[i], cyc);
      check("throughput_cycles", cyc, 1);
    end
    repeat (2) tick();

    // Back-pressure: A,B fill both entries, C held off until drain
    a = model(64'h1000, 32'h00100093);
    b = model(64'h1004, 32'h00200113);
    c = model(64'h1008, 32'h00300193);
    out_ready = 1'b0;
    send(a, cyc);
    send(b, cyc);
    check("bp_in_ready", in_ready, 0);
    check("bp_occupancy", occupancy, 2);
    cur = c; in_valid = 1'b1; in_pc = c.pc; in_instr = c.instr;
    tick();
    check("bp_c_held", acc_flag, 0);
    check("bp_head_is_a", out_pc, 64'h1000);
    out_ready = 1'b1;
    tick();
    check("drain_in_ready", in_ready, 1);
    check("drain_head_is_b", out_pc, 64'h1004);
    tick();
    check("drain_c_accepted", acc_flag, 1);
    in_valid = 1'b0;
    check("drain_head_is_c", out_pc, 64'h1008);
    tick();
    check("drain_empty", out_valid, 0);

    // Flush while full with an incoming beat pending
    out_ready = 1'b0;
    send(a, cyc);
    send(b, cyc);
    cur = c; in_valid = 1'b1; in_pc = c.pc; in_instr = c.instr; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_occupancy", occupancy, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush with a fire and an accept in the same cycle
    out_ready = 1'b0;
    send(a, cyc);
    out_ready = 1'b1;
    cur = b; in_valid = 1'b1; in_pc = b.pc; in_instr = b.instr; flush = 1'b1;
    tick();
    check("flush2_accepted", acc_flag, 1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 0);
    repeat (3) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(a, cyc);
    send(b, cyc);
    #2;
    rst_n = 1'b0;
    #1;
    reset_values("async_rst");
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic with source-held beats
    pending = 1'b0; sent = 0; nxt = a;
    while (sent < 300) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        r = $urandom();
        nxt = model({$urandom(), $urandom()}, {r[31:7], ops[$urandom_range(0, 15)]});
        pending = 1'b1;
      end
      cur = nxt; in_valid = pending; in_pc = nxt.pc; in_instr = nxt.instr;
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
      if (acc_flag) begin
        pending = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
